// File: rtl/logit_collector_10.sv
// logit_collector_10
//   Producer side of the 10-class argmax interface. Accepts signed partial sums
//   as a valid/ready stream in class order, and accumulates NUM_PASSES beats per
//   class into a 64-bit logit. It then presents the 10 logits, pulses am_start
//   and waits for am_done. The winning class is captured into a result
//   handshake. Finally the argmax unit is re-armed for the next image.
//
// Ports
//   clk, resetn                  clock, synchronous active-low reset
//   s_valid/s_ready/s_data/s_last  partial-sum input stream
//   logit0..logit9               signed 64-bit logits to argmax
//   am_start                     one-cycle argmax start pulse
//   am_rearm_n                   one-cycle active-low argmax re-arm
//   am_done, am_max_index        argmax completion and winning class
//   res_valid/res_ready/res_index  result handshake toward MMIO
//   frame_err, timeout_err       sticky error flags
//   err_clr                      clears both sticky flags

module logit_collector_10 #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned IN_W        = 32,
  parameter int unsigned NUM_PASSES  = 1,
  parameter int unsigned TIMEOUT     = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [IN_W-1:0]        s_data,
  input  logic                   s_last,
  output logic [63:0]            logit0,
  output logic [63:0]            logit1,
  output logic [63:0]            logit2,
  output logic [63:0]            logit3,
  output logic [63:0]            logit4,
  output logic [63:0]            logit5,
  output logic [63:0]            logit6,
  output logic [63:0]            logit7,
  output logic [63:0]            logit8,
  output logic [63:0]            logit9,
  output logic                   am_start,
  output logic                   am_rearm_n,
  input  logic                   am_done,
  input  logic [3:0]             am_max_index,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [3:0]             res_index,
  output logic                   frame_err,
  output logic                   timeout_err,
  input  logic                   err_clr
);

  localparam int unsigned CW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int unsigned PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CW-1:0] LastCls  = CW'(NUM_CLASSES - 1);
  localparam logic [PW-1:0] LastPass = PW'(NUM_PASSES - 1);
  localparam logic [TW-1:0] LastTick = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StCollect,
    StStart,
    StWait,
    StReport,
    StRearm
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cls_q;
  logic [PW-1:0]   pass_q;
  logic [TW-1:0]   timer_q;
  logic [63:0]     logit_q [NUM_CLASSES];

  logic [63:0]     s_sext;
  logic            final_beat;

  assign s_sext     = {{(64 - IN_W){s_data[IN_W-1]}}, s_data};
  assign final_beat = (cls_q == LastCls) && (pass_q == LastPass);

  // Only COLLECT accepts beats; decoded straight from the state register.
  assign s_ready = (state_q == StCollect);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= StCollect;
      cls_q       <= '0;
      pass_q      <= '0;
      timer_q     <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) begin
        logit_q[i] <= '0;
      end
      am_start    <= 1'b0;
      am_rearm_n  <= 1'b1;
      res_valid   <= 1'b0;
      res_index   <= '0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      am_start   <= 1'b0;
      am_rearm_n <= 1'b1;

      // Clear first so a set event later in this block takes precedence.
      if (err_clr) begin
        frame_err   <= 1'b0;
        timeout_err <= 1'b0;
      end

      unique case (state_q)
        StCollect: begin
          if (s_valid) begin
            if (pass_q == '0) begin
              logit_q[cls_q] <= s_sext;
            end else begin
              logit_q[cls_q] <= logit_q[cls_q] + s_sext;
            end

            if (final_beat) begin
              cls_q  <= '0;
              pass_q <= '0;
              if (s_last) begin
                state_q  <= StStart;
                am_start <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end else if (s_last) begin
              // Early s_last: drop the frame, the next one overwrites the logits.
              frame_err <= 1'b1;
              cls_q     <= '0;
              pass_q    <= '0;
            end else if (cls_q == LastCls) begin
              cls_q  <= '0;
              pass_q <= pass_q + 1'b1;
            end else begin
              cls_q <= cls_q + 1'b1;
            end
          end
        end

        StStart: begin
          timer_q <= '0;
          state_q <= StWait;
        end

        StWait: begin
          if (am_done) begin
            res_index <= am_max_index;
            res_valid <= 1'b1;
            state_q   <= StReport;
          end else if (timer_q == LastTick) begin
            timeout_err <= 1'b1;
            am_rearm_n  <= 1'b0;
            state_q     <= StRearm;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        StReport: begin
          if (res_ready) begin
            res_valid  <= 1'b0;
            am_rearm_n <= 1'b0;
            state_q    <= StRearm;
          end
        end

        StRearm: begin
          cls_q   <= '0;
          pass_q  <= '0;
          state_q <= StCollect;
        end

        default: begin
          state_q <= StCollect;
        end
      endcase
    end
  end

  assign logit0 = logit_q[0];
  assign logit1 = logit_q[1];
  assign logit2 = logit_q[2];
  assign logit3 = logit_q[3];
  assign logit4 = logit_q[4];
  assign logit5 = logit_q[5];
  assign logit6 = logit_q[6];
  assign logit7 = logit_q[7];
  assign logit8 = logit_q[8];
  assign logit9 = logit_q[9];

endmodule

// File: tb/tb_logit_collector_10.sv
// Directed testbench for logit_collector_10. Instance dut uses NUM_PASSES=1 and
// instance dut2 uses NUM_PASSES=2. The two share every input except s_valid.
module tb_logit_collector_10;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_valid2 = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        am_done = 1'b0;
  logic [3:0]  am_max_index = '0;
  logic        res_ready = 1'b0;
  logic        err_clr = 1'b0;

  logic        s_ready, am_start, am_rearm_n, res_valid, frame_err, timeout_err;
  logic [3:0]  res_index;
  logic [63:0] logit0, logit1, logit2, logit3, logit4, logit5, logit6, logit7, logit8, logit9;

  logic        s_ready2, am_start2, am_rearm_n2, res_valid2, frame_err2, timeout_err2;
  logic [3:0]  res_index2;
  logic [63:0] l2_0, l2_1, l2_2, l2_3, l2_4, l2_5, l2_6, l2_7, l2_8, l2_9;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] fdata [20];

  always #5 clk = ~clk;

  logit_collector_10 #(.NUM_PASSES(1), .TIMEOUT(32)) dut (
    .clk(clk), .resetn(resetn), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .logit0(logit0), .logit1(logit1), .logit2(logit2), .logit3(logit3),
    .logit4(logit4), .logit5(logit5), .logit6(logit6), .logit7(logit7), .logit8(logit8),
    .logit9(logit9), .am_start(am_start), .am_rearm_n(am_rearm_n), .am_done(am_done),
    .am_max_index(am_max_index), .res_valid(res_valid), .res_ready(res_ready),
    .res_index(res_index), .frame_err(frame_err), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  logit_collector_10 #(.NUM_PASSES(2), .TIMEOUT(32)) dut2 (
    .clk(clk), .resetn(resetn), .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data),
    .s_last(s_last), .logit0(l2_0), .logit1(l2_1), .logit2(l2_2), .logit3(l2_3),
    .logit4(l2_4), .logit5(l2_5), .logit6(l2_6), .logit7(l2_7), .logit8(l2_8),
    .logit9(l2_9), .am_start(am_start2), .am_rearm_n(am_rearm_n2), .am_done(am_done),
    .am_max_index(am_max_index), .res_valid(res_valid2), .res_ready(res_ready),
    .res_index(res_index2), .frame_err(frame_err2), .timeout_err(timeout_err2),
    .err_clr(err_clr)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Sends fdata[first .. first+n-1]; s_last on the 1-based beat number last_at (0: none).
  task automatic send_beats(input int first, input int n, input int last_at, input bit to2);
    for (int i = 0; i < n; i++) begin
      if (to2) s_valid2 = 1'b1;
      else s_valid = 1'b1;
      s_data = fdata[first + i];
      s_last = (first + i + 1 == last_at);
      tick();
    end
    s_valid = 1'b0;
    s_valid2 = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic do_reset;
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  // Called right after am_start is observed: answer with idx and drain the result.
  task automatic finish_frame(input logic [3:0] idx, input string tag);
    tick();
    am_done = 1'b1;
    am_max_index = idx;
    tick();
    vectors++;
    if (res_valid !== 1'b1 || res_index !== idx || s_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_result: got valid=%b idx=%0d ready=%b want valid=1 idx=%0d ready=0",
               tag, res_valid, res_index, s_ready, idx);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    am_done = 1'b0;
    vectors++;
    if (res_valid !== 1'b0 || am_rearm_n !== 1'b0 || s_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_rearm: got valid=%b rearm_n=%b ready=%b want 0 0 0",
               tag, res_valid, am_rearm_n, s_ready);
    end
    tick();
    vectors++;
    if (am_rearm_n !== 1'b1 || s_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_collect: got rearm_n=%b ready=%b want 1 1", tag, am_rearm_n, s_ready);
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    tick();
    tick();
    vectors++;
    if (am_start !== 1'b0 || am_rearm_n !== 1'b1 || res_valid !== 1'b0 || res_index !== 4'd0 ||
        frame_err !== 1'b0 || timeout_err !== 1'b0 || logit0 !== 64'd0 || logit9 !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_values: got start=%b rearm_n=%b rv=%b ri=%0d fe=%b te=%b l0=%h l9=%h",
               am_start, am_rearm_n, res_valid, res_index, frame_err, timeout_err, logit0, logit9);
    end
    resetn = 1'b1;
    tick();
    vectors++;
    if (s_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 1", s_ready);
    end
  endtask

  task automatic test_basic;
    for (int i = 0; i < 10; i++) fdata[i] = 32'((i + 1) * 10);
    send_beats(0, 9, 10, 1'b0);
    vectors++;
    if (am_start !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_early_start: got %b want 0", am_start);
    end
    send_beats(9, 1, 10, 1'b0);
    vectors++;
    if (am_start !== 1'b1 || s_ready !== 1'b0 || logit9 !== 64'd100 || logit0 !== 64'd10 ||
        logit4 !== 64'd50) begin
      miscompares++;
      $display("FAIL basic_start: got start=%b ready=%b l0=%0d l4=%0d l9=%0d want 1 0 10 50 100",
               am_start, s_ready, logit0, logit4, logit9);
    end
    finish_frame(4'd9, "basic");
  endtask

  task automatic test_negative;
    fdata[0] = -32'sd5;  fdata[1] = -32'sd1;  fdata[2] = -32'sd9;  fdata[3] = -32'sd7;
    fdata[4] = -32'sd3;  fdata[5] = -32'sd20; fdata[6] = -32'sd8;  fdata[7] = -32'sd6;
    fdata[8] = -32'sd4;  fdata[9] = -32'sd2;
    send_beats(0, 10, 10, 1'b0);
    vectors++;
    if (am_start !== 1'b1 || logit1 !== 64'hFFFF_FFFF_FFFF_FFFF ||
        logit0 !== 64'hFFFF_FFFF_FFFF_FFFB || logit5 !== 64'hFFFF_FFFF_FFFF_FFEC) begin
      miscompares++;
      $display("FAIL neg_sext: got start=%b l0=%h l1=%h l5=%h", am_start, logit0, logit1, logit5);
    end
    finish_frame(4'd1, "neg");
  endtask

  task automatic test_two_pass;
    for (int k = 0; k < 10; k++) begin
      fdata[k] = 32'(k);
      fdata[10 + k] = 32'd3;
    end
    send_beats(0, 10, 20, 1'b1);
    vectors++;
    if (am_start2 !== 1'b0 || s_ready2 !== 1'b1) begin
      miscompares++;
      $display("FAIL pass2_mid: got start=%b ready=%b want 0 1", am_start2, s_ready2);
    end
    send_beats(10, 10, 20, 1'b1);
    vectors++;
    if (am_start2 !== 1'b1 || l2_0 !== 64'd3 || l2_5 !== 64'd8 || l2_9 !== 64'd12 ||
        frame_err2 !== 1'b0) begin
      miscompares++;
      $display("FAIL pass2_end: got start=%b l0=%0d l5=%0d l9=%0d fe=%b want 1 3 8 12 0",
               am_start2, l2_0, l2_5, l2_9, frame_err2);
    end
    do_reset();
  endtask

  task automatic test_frame_err;
    for (int i = 0; i < 10; i++) fdata[i] = 32'd77;
    send_beats(0, 4, 4, 1'b0);
    vectors++;
    if (frame_err !== 1'b1 || am_start !== 1'b0 || logit3 !== 64'd77) begin
      miscompares++;
      $display("FAIL ferr_early: got fe=%b start=%b l3=%0d want 1 0 77", frame_err, am_start,
               logit3);
    end
    for (int i = 0; i < 10; i++) fdata[i] = 32'(i + 1);
    send_beats(0, 10, 10, 1'b0);
    vectors++;
    if (am_start !== 1'b1 || logit0 !== 64'd1 || logit3 !== 64'd4 || logit9 !== 64'd10 ||
        frame_err !== 1'b1) begin
      miscompares++;
      $display("FAIL ferr_clean: got start=%b l0=%0d l3=%0d l9=%0d fe=%b want 1 1 4 10 1",
               am_start, logit0, logit3, logit9, frame_err);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    vectors++;
    if (frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL ferr_clear: got %b want 0", frame_err);
    end
    // Now in WAIT; answer and drain.
    am_done = 1'b1;
    am_max_index = 4'd9;
    tick();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    am_done = 1'b0;
    tick();
    // Full frame without s_last on the final beat.
    send_beats(0, 10, 0, 1'b0);
    vectors++;
    if (frame_err !== 1'b1 || am_start !== 1'b0 || s_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ferr_nolast: got fe=%b start=%b ready=%b want 1 0 1", frame_err, am_start,
               s_ready);
    end
    // Set and clear in the same cycle: set wins.
    fdata[0] = 32'd5;
    err_clr = 1'b1;
    send_beats(0, 1, 1, 1'b0);
    err_clr = 1'b0;
    vectors++;
    if (frame_err !== 1'b1) begin
      miscompares++;
      $display("FAIL ferr_setwins: got %b want 1", frame_err);
    end
    do_reset();
  endtask

  task automatic test_timeout;
    for (int i = 0; i < 10; i++) fdata[i] = 32'd1;
    send_beats(0, 10, 10, 1'b0);
    vectors++;
    if (am_start !== 1'b1) begin
      miscompares++;
      $display("FAIL tmo_start: got %b want 1", am_start);
    end
    for (int i = 0; i < 32; i++) tick();
    vectors++;
    if (timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL tmo_early: got %b want 0", timeout_err);
    end
    tick();
    vectors++;
    if (timeout_err !== 1'b1 || am_rearm_n !== 1'b0 || s_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL tmo_set: got te=%b rearm_n=%b ready=%b want 1 0 0", timeout_err,
               am_rearm_n, s_ready);
    end
    tick();
    vectors++;
    if (am_rearm_n !== 1'b1 || s_ready !== 1'b1 || timeout_err !== 1'b1) begin
      miscompares++;
      $display("FAIL tmo_after: got rearm_n=%b ready=%b te=%b want 1 1 1", am_rearm_n, s_ready,
               timeout_err);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    vectors++;
    if (timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL tmo_clear: got %b want 0", timeout_err);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 10; i++) fdata[i] = 32'(i * 2);
    send_beats(0, 10, 10, 1'b0);
    tick();
    am_done = 1'b1;
    am_max_index = 4'd4;
    tick();
    am_max_index = 4'd0;
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (res_valid !== 1'b1 || res_index !== 4'd4 || s_ready !== 1'b0 || logit9 !== 64'd18) begin
        miscompares++;
        $display("FAIL b2b_hold%0d: got rv=%b ri=%0d ready=%b l9=%0d want 1 4 0 18", c, res_valid,
                 res_index, s_ready, logit9);
      end
      tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    am_done = 1'b0;
    vectors++;
    if (am_rearm_n !== 1'b0 || res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_rearm: got rearm_n=%b rv=%b want 0 0", am_rearm_n, res_valid);
    end
    tick();
    for (int i = 0; i < 10; i++) fdata[i] = 32'(100 - i);
    send_beats(0, 10, 10, 1'b0);
    vectors++;
    if (am_start !== 1'b1 || logit0 !== 64'd100 || logit9 !== 64'd91) begin
      miscompares++;
      $display("FAIL b2b_second: got start=%b l0=%0d l9=%0d want 1 100 91", am_start, logit0,
               logit9);
    end
    finish_frame(4'd0, "b2b");
  endtask

  task automatic test_mid_reset;
    for (int i = 0; i < 10; i++) fdata[i] = 32'd9;
    send_beats(0, 6, 0, 1'b0);
    resetn = 1'b0;
    tick();
    vectors++;
    if (logit0 !== 64'd0 || logit5 !== 64'd0 || am_start !== 1'b0 || am_rearm_n !== 1'b1 ||
        res_valid !== 1'b0 || frame_err !== 1'b0 || timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL mrst_values: got l0=%0d l5=%0d start=%b rearm_n=%b rv=%b fe=%b te=%b",
               logit0, logit5, am_start, am_rearm_n, res_valid, frame_err, timeout_err);
    end
    resetn = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) fdata[i] = 32'(i + 3);
    send_beats(0, 10, 10, 1'b0);
    vectors++;
    if (am_start !== 1'b1 || frame_err !== 1'b0 || logit0 !== 64'd3 || logit9 !== 64'd12) begin
      miscompares++;
      $display("FAIL mrst_frame: got start=%b fe=%b l0=%0d l9=%0d want 1 0 3 12", am_start,
               frame_err, logit0, logit9);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_two_pass();
    test_frame_err();
    test_timeout();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
